approx_response_checker: RTL

- Hardware response end of the exhaustive-vector flow used for partitioned approximate blocks: sweeps every input pattern of a combinational sub-circuit, samples approximate and exact outputs, and accumulates error metrics.
- Replaces simulation-only stimulus/print benches for on-FPGA error characterisation.
- Sits between the sweep controller (start/done) and a DUT pair: the exact netlist and the approximated netlist, both fed from pi_o.

---
 rtl/approx_chk_pkg.sv | 39 +++
 rtl/approx_response_checker_metric.sv | 31 +++
 rtl/approx_response_checker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/approx_chk_pkg.sv
// approx_chk_pkg: shared types, constants and width helpers for the
// approximate-vs-exact response checker.
//   - chk_state_e : sweep FSM states
//   - MISR_POLY / MISR_SEED and misr_step() : response signature (used only
//     when SIG_MISR_EN is defined)
//   - err_cnt_w / popcnt_w / hd_sum_w : accumulator widths sized so they can
//     never overflow over a full sweep
package approx_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  // err_cnt can reach 2^in_w, so it needs one extra bit.
  function automatic int err_cnt_w(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int popcnt_w(input int out_w);
    return $clog2(out_w + 1);
  endfunction

  // hd_sum can reach 2^in_w * out_w.
  function automatic int hd_sum_w(input int in_w, input int out_w);
    return in_w + $clog2(out_w + 1);
  endfunction

  // One MISR step: Galois-style shift with feedback, then fold in the data.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0) ^ d;
  endfunction

endpackage

// File: rtl/approx_response_checker_metric.sv
// approx_err_metric: purely combinational per-vector error metrics.
//   approx, exact : DUT output pair
//   mismatch      : approx != exact
//   popcnt        : popcount(approx ^ exact) (Hamming distance)
//   abs_diff      : unsigned |approx - exact|
module approx_err_metric
  import approx_chk_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic [OUT_W-1:0]              approx,
  input  logic [OUT_W-1:0]              exact,
  output logic                          mismatch,
  output logic [popcnt_w(OUT_W)-1:0]    popcnt,
  output logic [OUT_W-1:0]              abs_diff
);

  localparam int PC_W = popcnt_w(OUT_W);

  logic [OUT_W-1:0] diff_bits;

  assign diff_bits = approx ^ exact;
  assign mismatch  = |diff_bits;
  assign abs_diff  = (approx >= exact) ? (approx - exact) : (exact - approx);

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < OUT_W; i++) popcnt = popcnt + PC_W'(diff_bits[i]);
  end

endmodule

// File: rtl/approx_response_checker.sv
// approx_response_checker: drives every input pattern of a combinational
// sub-circuit pair (exact and approximated netlists) and accumulates error
// metrics between their outputs.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : pulse; starts a sweep from IDLE or DONE
//   pi_o              : vector applied to both DUTs
//   po_approx_i/exact : DUT outputs
//   busy, done        : sweep in progress / results valid (level)
//   err_cnt, hd_sum, max_abs_err, first_err_vec, first_err_valid : metrics
//   sig_o             : MISR signature of {approx, exact}, only when the
//                       SIG_MISR_EN macro is defined
module approx_response_checker
  import approx_chk_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [IN_W-1:0]                   pi_o,
  input  logic [OUT_W-1:0]                  po_approx_i,
  input  logic [OUT_W-1:0]                  po_exact_i,
  output logic                              busy,
  output logic                              done,
  output logic [err_cnt_w(IN_W)-1:0]        err_cnt,
  output logic [hd_sum_w(IN_W, OUT_W)-1:0]  hd_sum,
  output logic [OUT_W-1:0]                  max_abs_err,
  output logic [IN_W-1:0]                   first_err_vec,
`ifdef SIG_MISR_EN
  output logic [31:0]                       sig_o,
`endif
  output logic                              first_err_valid
);

  localparam int CNT_W = err_cnt_w(IN_W);
  localparam int HD_W  = hd_sum_w(IN_W, OUT_W);
  localparam int PC_W  = popcnt_w(OUT_W);
  localparam logic [CNT_W-1:0] LAST_VEC  = CNT_W'((1 << IN_W) - 1);
  localparam logic [3:0]       HOLD_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam chk_state_e       ST_AFTER  = (SETTLE > 0) ? ST_HOLD : ST_SAMPLE;

  chk_state_e       state, state_nxt;
  logic [CNT_W-1:0] vec;        // wide enough that it never wraps
  logic [3:0]       settle_cnt;
  logic             last_vec;

  logic             mismatch;
  logic [PC_W-1:0]  popcnt;
  logic [OUT_W-1:0] abs_diff;

  approx_err_metric #(.OUT_W(OUT_W)) u_metric (
    .approx   (po_approx_i),
    .exact    (po_exact_i),
    .mismatch (mismatch),
    .popcnt   (popcnt),
    .abs_diff (abs_diff)
  );

  assign pi_o     = vec[IN_W-1:0];
  assign last_vec = (vec == LAST_VEC);
  assign busy     = (state == ST_HOLD) || (state == ST_SAMPLE);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_AFTER;
      ST_HOLD:          if (settle_cnt == HOLD_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE:        state_nxt = last_vec ? ST_DONE : ST_AFTER;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec             <= '0;
      settle_cnt      <= '0;
      err_cnt         <= '0;
      hd_sum          <= '0;
      max_abs_err     <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec             <= '0;
            settle_cnt      <= '0;
            err_cnt         <= '0;
            hd_sum          <= '0;
            max_abs_err     <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          settle_cnt <= (settle_cnt == HOLD_LAST) ? 4'd0 : settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + CNT_W'(1);
            hd_sum  <= hd_sum + HD_W'(popcnt);
            if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
            if (!first_err_valid) begin
              first_err_vec   <= pi_o;
              first_err_valid <= 1'b1;
            end
          end
          // Terminal vector keeps pi_o on its last value for the DONE state.
          if (!last_vec) vec <= vec + CNT_W'(1);
          settle_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SIG_MISR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_o <= MISR_SEED;
    end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
      sig_o <= MISR_SEED;
    end else if (state == ST_SAMPLE) begin
      sig_o <= misr_step(sig_o, 32'({po_approx_i, po_exact_i}));
    end
  end
`endif

endmodule
